ma_stage: RTL

- Memory-access pipeline stage. Consumes the EX→MA bundle: ALU result, store operand OP2, instruction, PC, and the isSt/isLd/isWb/isCall flags.
- Performs the data-memory load/store through a valid/ready memory port.
- Registers the MA→RW bundle for the writeback stage.
- Back-pressures EX/decode with a stall signal while a memory access is outstanding.

---
 rtl/ma_stage_pkg.sv | 17 +
 rtl/ma_stage_if.sv | 25 ++
 rtl/ma_mem_if.sv | 77 +++++++
 rtl/ma_stage.sv | 136 +++++++++++++
 4 files changed

// File: rtl/ma_stage_pkg.sv
// ma_stage_pkg: shared memory-access stage types and constants.
package ma_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ma_state_e;

    localparam int          MA_DATA_W  = 32;
    localparam logic [31:0] MA_POISON  = 32'hDEADBEEF;
    // MA->RW flag vector layout: {is_ld, is_wb, is_call}
    localparam int          MR_FLAGS_W = 3;
    localparam int          MR_F_LD    = 2;
    localparam int          MR_F_WB    = 1;
    localparam int          MR_F_CALL  = 0;

endpackage

// File: rtl/ma_stage_if.sv
// ma_stage_if: valid/ready data-memory port between the MA stage and memory.
interface ma_stage_if
    import ma_stage_pkg::*;
#(
    parameter int DATA_W = MA_DATA_W
);

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/ma_mem_if.sv
// ma_mem_if: request holding registers and IDLE/WAIT handshake FSM; abort counter under MA_TIMEOUT_EN.
module ma_mem_if
    import ma_stage_pkg::*;
#(
    parameter int DATA_W = MA_DATA_W
`ifdef MA_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [DATA_W-1:0] rdata_o,
    ma_stage_if.master        mem
);

    ma_state_e         state_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Latch the request on entry to WAIT and leave on completion or abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE) begin
            if (start_i) begin
                state_q <= WAIT;
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
        end else if (done_o || timeout_o) begin
            state_q <= IDLE;
        end
    end

    assign busy_o        = state_q == WAIT;
    assign done_o        = busy_o & mem.mem_ready;
    assign rdata_o       = mem.mem_rdata;
    assign mem.mem_req   = busy_o;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

`ifdef MA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] cnt_q;

    // Count WAIT cycles without ready; cleared whenever a new access starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start_i && !busy_o) begin
            cnt_q <= '0;
        end else if (busy_o && !mem.mem_ready) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Abort on the cycle that would bring the count to TIMEOUT_CYCLES; ready wins
    assign timeout_o = busy_o & ~mem.mem_ready & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/ma_stage.sv
// ma_stage: memory-access pipeline stage with MA->RW register; MA_TIMEOUT_EN enables the access abort.
module ma_stage
    import ma_stage_pkg::*;
#(
    parameter int DATA_W = MA_DATA_W
`ifdef MA_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              em_valid,
    input  logic [DATA_W-1:0] em_aluresult,
    input  logic [DATA_W-1:0] em_op2,
    input  logic [DATA_W-1:0] em_inst,
    input  logic [DATA_W-1:0] em_pc,
    input  logic              em_is_ld,
    input  logic              em_is_st,
    input  logic              em_is_wb,
    input  logic              em_is_call,
    output logic              ma_stall,
    ma_stage_if.master        mem,
    output logic              mr_valid,
    output logic [DATA_W-1:0] mr_aluresult,
    output logic [DATA_W-1:0] mr_ldresult,
    output logic [DATA_W-1:0] mr_pc,
    output logic [DATA_W-1:0] mr_inst,
    output logic              mr_is_ld,
    output logic              mr_is_wb,
    output logic              mr_is_call,
    output logic              mem_err
);

    logic                  busy, done, tout;
    logic [DATA_W-1:0]     rdata;
    logic                  accept, mem_op, start, alu_take;
    logic [DATA_W-1:0]     h_alu_q, h_pc_q, h_inst_q;
    logic [MR_FLAGS_W-1:0] h_flags_q;
    logic                  mr_valid_q;
    logic [DATA_W-1:0]     mr_alu_q, mr_ld_q, mr_pc_q, mr_inst_q;
    logic [MR_FLAGS_W-1:0] mr_flags_q;

    assign accept   = em_valid & ~busy;
    assign mem_op   = em_is_ld | em_is_st;
    assign start    = accept & mem_op;
    assign alu_take = accept & ~mem_op;
    assign ma_stall = busy;

    ma_mem_if #(
        .DATA_W         (DATA_W)
`ifdef MA_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .we_i      (em_is_st & ~em_is_ld),
        .addr_i    (em_aluresult),
        .wdata_i   (em_op2),
        .busy_o    (busy),
        .done_o    (done),
        .timeout_o (tout),
        .rdata_o   (rdata),
        .mem       (mem)
    );

    // Hold the non-memory half of the bundle while the access is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_alu_q   <= '0;
            h_pc_q    <= '0;
            h_inst_q  <= '0;
            h_flags_q <= '0;
        end else if (start) begin
            h_alu_q   <= em_aluresult;
            h_pc_q    <= em_pc;
            h_inst_q  <= em_inst;
            h_flags_q <= {em_is_ld, em_is_wb, em_is_call};
        end
    end

    // MA->RW register: direct capture for ALU ops, from holding regs on completion or abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mr_valid_q <= 1'b0;
            mr_alu_q   <= '0;
            mr_ld_q    <= '0;
            mr_pc_q    <= '0;
            mr_inst_q  <= '0;
            mr_flags_q <= '0;
        end else begin
            mr_valid_q <= alu_take | done | tout;
            if (alu_take) begin
                mr_alu_q   <= em_aluresult;
                mr_ld_q    <= '0;
                mr_pc_q    <= em_pc;
                mr_inst_q  <= em_inst;
                mr_flags_q <= {1'b0, em_is_wb, em_is_call};
            end else if (done || tout) begin
                mr_alu_q   <= h_alu_q;
                mr_ld_q    <= tout ? DATA_W'(MA_POISON) : (h_flags_q[MR_F_LD] ? rdata : '0);
                mr_pc_q    <= h_pc_q;
                mr_inst_q  <= h_inst_q;
                mr_flags_q <= {h_flags_q[MR_F_LD], h_flags_q[MR_F_WB] & ~tout, h_flags_q[MR_F_CALL]};
            end
        end
    end

`ifdef MA_TIMEOUT_EN
    logic err_q;

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (tout) begin
            err_q <= 1'b1;
        end
    end

    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign mr_valid     = mr_valid_q;
    assign mr_aluresult = mr_alu_q;
    assign mr_ldresult  = mr_ld_q;
    assign mr_pc        = mr_pc_q;
    assign mr_inst      = mr_inst_q;
    assign mr_is_ld     = mr_flags_q[MR_F_LD];
    assign mr_is_wb     = mr_flags_q[MR_F_WB];
    assign mr_is_call   = mr_flags_q[MR_F_CALL];

endmodule
